// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and defaults for apb_master_arbiter.
//   apb_state_e         - APB sequencer state (IDLE / SETUP / ACCESS)
//   TIMEOUT_CYC_DEFAULT - default ACCESS wait limit when APB_TIMEOUT_EN is defined
//   wrap_inc()          - index increment modulo n, used for the round-robin pointer

package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 16;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester-side handshake and APB master bus bundle.
//   Requester side: req_valid/req_write/req_addr/req_wdata in, req_ready out,
//                   rsp_valid/rsp_rdata/rsp_err out (packed per-requester slices).
//   APB side:       Psel/Penable/Pwrite/Paddr/Pwdata out, Prdata/Pready/Pslverr in.
// Modports:
//   master - view of apb_master_arbiter
//   slave  - view of the surrounding fabric / APB slave (or a testbench)

interface apb_master_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    logic                      Psel;
    logic                      Penable;
    logic                      Pwrite;
    logic [ADDR_W-1:0]         Paddr;
    logic [DATA_W-1:0]         Pwdata;
    logic [DATA_W-1:0]         Prdata;
    logic                      Pready;
    logic                      Pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, Prdata, Pready, Pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, Psel, Penable, Pwrite, Paddr, Pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, Prdata, Pready, Pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, Psel, Penable, Pwrite, Paddr, Pwdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i - request vector
//   ptr_i - highest-priority index for this pick
//   gnt_o - one-hot grant (all zero when no request)
//   idx_o - index of the granted requester (0 when no request)
// The first asserted request at or after ptr_i wins, wrapping modulo NUM_REQ.

module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        int unsigned cand;
        logic        found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 32'(ptr_i);
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = IDX_W'(cand);
            end
            cand = wrap_inc(cand, NUM_REQ);
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port between NUM_REQ requesters.
//   Pclk   - APB clock
//   Preset - synchronous active-high reset
//   bus_io - apb_master_arbiter_if.master: requester handshake + APB master signals
// A round-robin pick is made in IDLE, or in the ACCESS cycle that sees Pready, so back-to-back
// transfers go ACCESS -> SETUP with no IDLE gap. The winner's payload is latched onto
// Paddr/Pwrite/Pwdata at accept and held until the next accept. Completion (rsp_valid to the
// owner) is registered and appears the cycle after ACCESS completes.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS that sees no Pready for
// TIMEOUT_CYC consecutive cycles; the abort returns rsp_err=1 with rsp_rdata=0.

module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input logic                  Pclk,
    input logic                  Preset,
    apb_master_arbiter_if.master bus_io
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("apb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 1");
    end

    apb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]  gnt;
    logic [IDX_W-1:0]    win_idx;
    logic                arb_point;
    logic                accept;
    logic                timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i (bus_io.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (win_idx)
    );

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts ACCESS cycles without Pready; cleared on every SETUP.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == SETUP) begin
            wait_cnt_d = '0;
        end else if (state_q == ACCESS && !bus_io.Pready) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // This is the TIMEOUT_CYC-th ACCESS cycle without Pready.
    assign timeout_hit = (state_q == ACCESS) && !bus_io.Pready &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign arb_point = (state_q == IDLE) || (state_q == ACCESS && bus_io.Pready);
    assign accept    = arb_point && (|bus_io.req_valid);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        // Payload only moves on accept, which keeps it stable through SETUP and ACCESS.
        if (accept) begin
            owner_d  = win_idx;
            ptr_d    = IDX_W'(wrap_inc(32'(win_idx), NUM_REQ));
            pwrite_d = bus_io.req_write[win_idx];
            paddr_d  = bus_io.req_addr[win_idx*ADDR_W +: ADDR_W];
            pwdata_d = bus_io.req_wdata[win_idx*DATA_W +: DATA_W];
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus_io.Pready) begin
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_rdata_d = pwrite_q ? '0 : bus_io.Prdata;
                    rsp_err_d   = bus_io.Pslverr;
                    penable_d   = 1'b0;
                    if (accept) begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        psel_d  = 1'b0;
                    end
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_err_d   = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // req_ready is the only combinational output; held low while reset is asserted.
    assign bus_io.req_ready = (arb_point && !Preset) ? gnt : '0;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;
    assign bus_io.rsp_err   = rsp_err_q;
    assign bus_io.Psel      = psel_q;
    assign bus_io.Penable   = penable_q;
    assign bus_io.Pwrite    = pwrite_q;
    assign bus_io.Paddr     = paddr_q;
    assign bus_io.Pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed self-checking bench for apb_master_arbiter (NUM_REQ=2).
// Inputs change 2 time units after the rising edge; outputs are sampled there too
// (and 1 unit later for the combinational req_ready). Honours APB_TIMEOUT_EN.

module tb_apb_master_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    apb_master_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_arbiter #(
        .NUM_REQ     (2),
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (16)
    ) u_dut (
        .Pclk   (clk),
        .Preset (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.Prdata    = '0;
        bus.Pready    = 1'b0;
        bus.Pslverr   = 1'b0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data);
        bus.req_valid[i]          = 1'b1;
        bus.req_write[i]          = wr;
        bus.req_addr[i*32 +: 32]  = addr;
        bus.req_wdata[i*32 +: 32] = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        bus.req_valid = 2'b11;
        #1;
        checks++; if ({bus.Psel, bus.Penable, bus.Pwrite} !== 3'b000) begin errors++;
            $display("FAIL reset_ctrl: got %b want 000", {bus.Psel, bus.Penable, bus.Pwrite}); end
        checks++; if ({bus.Paddr, bus.Pwdata} !== 64'h0) begin errors++;
            $display("FAIL reset_addr_data: got %h want 0", {bus.Paddr, bus.Pwdata}); end
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 35'h0) begin errors++;
            $display("FAIL reset_rsp: got %h want 0", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}); end
        checks++; if (bus.req_ready !== 2'b00) begin errors++;
            $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
        bus.req_valid = 2'b00;
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_zero_wait();
        bus.Pready = 1'b1;
        bus.Prdata = 32'hFFFF_FFFF;
        set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL wr_req_ready: got %b want 01", bus.req_ready); end
        step();  // T+1
        bus.req_valid[0] = 1'b0;
        checks++; if ({bus.Psel, bus.Penable, bus.Pwrite} !== 3'b101) begin errors++;
            $display("FAIL wr_setup_ctrl: got %b want 101", {bus.Psel, bus.Penable, bus.Pwrite}); end
        checks++; if ({bus.Paddr, bus.Pwdata} !== {32'h10, 32'hA5A5_0001}) begin errors++;
            $display("FAIL wr_setup_payload: got %h want %h", {bus.Paddr, bus.Pwdata},
                     {32'h10, 32'hA5A5_0001}); end
        step();  // T+2
        checks++; if ({bus.Psel, bus.Penable, bus.rsp_valid} !== 4'b1100) begin errors++;
            $display("FAIL wr_access: got %b want 1100", {bus.Psel, bus.Penable, bus.rsp_valid}); end
        step();  // T+3
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.Psel} !== 4'b0100) begin errors++;
            $display("FAIL wr_rsp: got %b want 0100", {bus.rsp_valid, bus.rsp_err, bus.Psel}); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++;
            $display("FAIL wr_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        step();  // T+4
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++;
            $display("FAIL wr_rsp_pulse: got %b want 00", bus.rsp_valid); end
        bus.Pready = 1'b0;
        bus.Prdata = '0;
    endtask

    task automatic test_read_wait();
        set_req(1, 1'b0, 32'h20, 32'h0);
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++;
            $display("FAIL rd_req_ready: got %b want 10", bus.req_ready); end
        step();  // T+1
        bus.req_valid[1] = 1'b0;
        checks++; if ({bus.Psel, bus.Penable, bus.Pwrite, bus.Paddr} !== {3'b100, 32'h20}) begin
            errors++; $display("FAIL rd_setup: got %h want %h",
                               {bus.Psel, bus.Penable, bus.Pwrite, bus.Paddr}, {3'b100, 32'h20}); end
        step();  // T+2
        for (int c = 2; c <= 5; c++) begin
            if (c == 5) begin
                bus.Pready = 1'b1;
                bus.Prdata = 32'hDEAD_BEEF;
            end
            checks++;
            if ({bus.rsp_valid, bus.Psel, bus.Penable, bus.Pwrite, bus.Paddr} !==
                {5'b00110, 32'h20}) begin
                errors++;
                $display("FAIL rd_access_T%0d: got %h want %h", c,
                         {bus.rsp_valid, bus.Psel, bus.Penable, bus.Pwrite, bus.Paddr},
                         {5'b00110, 32'h20});
            end
            step();
        end
        // T+6
        checks++; if ({bus.rsp_valid, bus.rsp_err} !== 3'b100) begin errors++;
            $display("FAIL rd_rsp: got %b want 100", {bus.rsp_valid, bus.rsp_err}); end
        checks++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL rd_rsp_rdata: got %h want deadbeef", bus.rsp_rdata); end
        bus.Pready = 1'b0;
        bus.Prdata = '0;
        step();
    endtask

    task automatic test_back_to_back();
        int          cnt [2];
        int          w;
        logic [31:0] exp_addr;
        logic [1:0]  exp_rv;
        logic [1:0]  exp_rdy;
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        bus.Pready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0;
            set_req(i, 1'b1, 32'h100 + 32'(i) * 32'h10, 32'hB000_0100 + 32'(i) * 32'h10);
        end
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL b2b_first_grant: got %b want 01", bus.req_ready); end
        for (int k = 0; k < 4; k++) begin
            w        = k % 2;
            exp_addr = 32'h100 + 32'(w) * 32'h10 + 32'(cnt[w]) * 32'h4;
            exp_rv   = (k == 0) ? 2'b00 : (2'b01 << (1 - w));
            step();  // SETUP
            cnt[w]++;
            if (cnt[w] == 2) bus.req_valid[w] = 1'b0;
            else set_req(w, 1'b1, exp_addr + 32'h4, 32'hB000_0000 + exp_addr + 32'h4);
            checks++;
            if ({bus.Psel, bus.Penable, bus.Paddr, bus.rsp_valid} !== {2'b10, exp_addr, exp_rv})
            begin
                errors++;
                $display("FAIL b2b_setup%0d: got %h want %h", k,
                         {bus.Psel, bus.Penable, bus.Paddr, bus.rsp_valid},
                         {2'b10, exp_addr, exp_rv});
            end
            checks++; if (bus.Pwdata !== 32'hB000_0000 + exp_addr) begin errors++;
                $display("FAIL b2b_wdata%0d: got %h want %h", k, bus.Pwdata,
                         32'hB000_0000 + exp_addr); end
            step();  // ACCESS
            #1;
            exp_rdy = (k < 3) ? (2'b01 << (1 - w)) : 2'b00;
            checks++; if ({bus.Psel, bus.Penable, bus.req_ready} !== {2'b11, exp_rdy}) begin
                errors++; $display("FAIL b2b_access%0d: got %b want %b", k,
                                   {bus.Psel, bus.Penable, bus.req_ready}, {2'b11, exp_rdy}); end
        end
        step();
        checks++; if ({bus.rsp_valid, bus.Psel, bus.Penable} !== 4'b1000) begin errors++;
            $display("FAIL b2b_last_rsp: got %b want 1000", {bus.rsp_valid, bus.Psel, bus.Penable}); end
        bus.Pready = 1'b0;
        step();
    endtask

    task automatic test_slverr();
        set_req(0, 1'b0, 32'h30, 32'h0);
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL err_req_ready: got %b want 01", bus.req_ready); end
        step();
        bus.req_valid[0] = 1'b0;
        step();  // ACCESS
        bus.Pready  = 1'b1;
        bus.Pslverr = 1'b1;
        bus.Prdata  = 32'h1234_5678;
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {3'b011, 32'h1234_5678}) begin
            errors++; $display("FAIL err_rsp: got %h want %h",
                               {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {3'b011, 32'h1234_5678});
        end
        bus.Pready  = 1'b0;
        bus.Pslverr = 1'b0;
        set_req(1, 1'b1, 32'h34, 32'h5555);
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++;
            $display("FAIL err_next_ready: got %b want 10", bus.req_ready); end
        step();
        bus.req_valid[1] = 1'b0;
        bus.Pslverr      = 1'b1;  // SETUP: must not be sampled
        step();  // ACCESS
        bus.Pready  = 1'b1;
        bus.Pslverr = 1'b0;
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL err_next_rsp: got %h want %h",
                               {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {3'b100, 32'h0}); end
        bus.Pready = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        logic ok;
        set_req(0, 1'b0, 32'h40, 32'h0);
        bus.Prdata = 32'hCAFE_F00D;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL to_req_ready: got %b want 01", bus.req_ready); end
        step();
        bus.req_valid[0] = 1'b0;
        step();  // first ACCESS cycle
        ok = 1'b1;
`ifdef APB_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            if ({bus.Psel, bus.Penable} !== 2'b11) ok = 1'b0;
            step();
        end
        checks++; if (ok !== 1'b1) begin errors++;
            $display("FAIL to_access_held: got %b want 1", ok); end
        checks++; if ({bus.Psel, bus.Penable, bus.rsp_valid, bus.rsp_err} !== 5'b00011) begin
            errors++; $display("FAIL to_abort: got %b want 00011",
                               {bus.Psel, bus.Penable, bus.rsp_valid, bus.rsp_err}); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++;
            $display("FAIL to_abort_rdata: got %h want 0", bus.rsp_rdata); end
        bus.Pready = 1'b1;  // late Pready after the abort
        step();
        checks++; if ({bus.Psel, bus.rsp_valid} !== 3'b000) begin errors++;
            $display("FAIL to_late_ready: got %b want 000", {bus.Psel, bus.rsp_valid}); end
`else
        for (int c = 0; c < 100; c++) begin
            if ({bus.Psel, bus.Penable, bus.rsp_valid} !== 4'b1100) ok = 1'b0;
            step();
        end
        checks++; if (ok !== 1'b1) begin errors++;
            $display("FAIL to_wait_forever: got %b want 1", ok); end
        bus.Pready = 1'b1;
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {3'b010, 32'hCAFE_F00D})
        begin
            errors++; $display("FAIL to_late_rsp: got %h want %h",
                               {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {3'b010, 32'hCAFE_F00D});
        end
`endif
        bus.Pready = 1'b0;
        bus.Prdata = '0;
        step();
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, 32'h50, 32'h7777);
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL rm_req_ready: got %b want 01", bus.req_ready); end
        step();
        bus.req_valid[0] = 1'b0;
        step();  // ACCESS, Pready low
        checks++; if ({bus.Psel, bus.Penable} !== 2'b11) begin errors++;
            $display("FAIL rm_access: got %b want 11", {bus.Psel, bus.Penable}); end
        rst = 1'b1;
        step();
        checks++; if ({bus.Psel, bus.Penable, bus.Pwrite, bus.rsp_valid, bus.rsp_err} !== 6'b0)
        begin
            errors++; $display("FAIL rm_ctrl: got %b want 000000",
                               {bus.Psel, bus.Penable, bus.Pwrite, bus.rsp_valid, bus.rsp_err});
        end
        checks++; if ({bus.Paddr, bus.Pwdata, bus.rsp_rdata} !== 96'h0) begin errors++;
            $display("FAIL rm_data: got %h want 0", {bus.Paddr, bus.Pwdata, bus.rsp_rdata}); end
        rst = 1'b0;
        set_req(0, 1'b0, 32'h60, 32'h0);
        set_req(1, 1'b0, 32'h64, 32'h0);
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL rm_ptr_reset: got %b want 01", bus.req_ready); end
        step();
        bus.req_valid[0] = 1'b0;
        checks++; if ({bus.Psel, bus.rsp_valid, bus.Paddr} !== {3'b100, 32'h60}) begin errors++;
            $display("FAIL rm_after_setup: got %h want %h", {bus.Psel, bus.rsp_valid, bus.Paddr},
                     {3'b100, 32'h60}); end
        step();  // ACCESS
        bus.Pready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++;
            $display("FAIL rm_next_grant: got %b want 10", bus.req_ready); end
        step();
        bus.req_valid[1] = 1'b0;
        bus.Pready       = 1'b0;
        checks++; if (bus.rsp_valid !== 2'b01) begin errors++;
            $display("FAIL rm_after_rsp: got %b want 01", bus.rsp_valid); end
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_back_to_back();
        test_slverr();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
